alu_op_controller: RTL and testbench

Sequencing controller for the ALU datapath and its overflow-select path. Accepts one operation request at a time over a valid/ready handshake, drives the ALU select and operand lines, and waits a fixed settle latency. It then captures the result and qualified overflow flag into a response register and maintains a sticky overflow status and a completed-operation counter. It sits between the instruction/control logic and the combinational ALU, so `Sel` is only ever changed under its control.

---
 rtl/alu_op_controller_if.sv | 53 +++++
 rtl/alu_op_controller.sv | 133 +++++++++++++
 tb/tb_alu_op_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_controller_if.sv
// Request, ALU and response signals between the instruction/control logic,
// the operation controller and the combinational ALU.
interface alu_op_controller_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 8;

    logic             ReqValid;
    logic             ReqReady;
    logic [OP_W-1:0]  ReqOp;
    logic [WIDTH-1:0] ReqA;
    logic [WIDTH-1:0] ReqB;

    logic [OP_W-1:0]  AluSel;
    logic [WIDTH-1:0] AluA;
    logic [WIDTH-1:0] AluB;
    logic [WIDTH-1:0] AluResult;
    logic             AluOverflow;

    logic             RspValid;
    logic             RspReady;
    logic [WIDTH-1:0] RspResult;
    logic             RspOverflow;

    logic             StickyOvf;
    logic             ClrSticky;
    logic [CNT_W-1:0] OpCount;

    // Environment side: requester, ALU and response consumer
    modport master (
        output ReqValid, ReqOp, ReqA, ReqB,
        input  ReqReady,
        input  AluSel, AluA, AluB,
        output AluResult, AluOverflow,
        input  RspValid, RspResult, RspOverflow,
        output RspReady,
        input  StickyOvf, OpCount,
        output ClrSticky
    );

    // Controller side
    modport slave (
        input  ReqValid, ReqOp, ReqA, ReqB,
        output ReqReady,
        output AluSel, AluA, AluB,
        input  AluResult, AluOverflow,
        output RspValid, RspResult, RspOverflow,
        input  RspReady,
        output StickyOvf, OpCount,
        input  ClrSticky
    );
endinterface

// File: rtl/alu_op_controller.sv
// Sequences one ALU operation at a time: launches operands, waits LAT settle
// cycles, captures result and qualified overflow, then holds the response.
module alu_op_controller #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    alu_op_controller_if.slave bus
);
    localparam int unsigned OP_W  = 3;
    localparam int unsigned OC_W  = 8;
    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             req_ready_q,   req_ready_d;
    logic [OP_W-1:0]  alu_sel_q,     alu_sel_d;
    logic [WIDTH-1:0] alu_a_q,       alu_a_d;
    logic [WIDTH-1:0] alu_b_q,       alu_b_d;
    logic             rsp_valid_q,   rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q,  rsp_result_d;
    logic             rsp_ovf_q,     rsp_ovf_d;
    logic             sticky_q,      sticky_d;
    logic [OC_W-1:0]  op_count_q,    op_count_d;

    logic             is_arith_c;
    logic             ovf_qual_c;
    logic             capture_c;

    // Overflow mux output is only meaningful for add/sub; mask it otherwise
    assign is_arith_c = (alu_sel_q == 3'b000) || (alu_sel_q == 3'b001);
    assign ovf_qual_c = is_arith_c ? bus.AluOverflow : 1'b0;
    assign capture_c  = (state_q == ST_EXEC) && (cnt_q == '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            alu_sel_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            sticky_q     <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
            sticky_q     <= sticky_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        sticky_d     = sticky_q;
        op_count_d   = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ReqValid && req_ready_q) begin
                    alu_sel_d = bus.ReqOp;
                    alu_a_d   = bus.ReqA;
                    alu_b_d   = bus.ReqB;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (capture_c) begin
                    rsp_result_d = bus.AluResult;
                    rsp_ovf_d    = ovf_qual_c;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.RspReady) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + OC_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A captured overflow outranks a simultaneous clear
        if (capture_c && ovf_qual_c) begin
            sticky_d = 1'b1;
        end else if (bus.ClrSticky) begin
            sticky_d = 1'b0;
        end

        req_ready_d = (state_d == ST_IDLE);
    end

    assign bus.ReqReady    = req_ready_q;
    assign bus.AluSel      = alu_sel_q;
    assign bus.AluA        = alu_a_q;
    assign bus.AluB        = alu_b_q;
    assign bus.RspValid    = rsp_valid_q;
    assign bus.RspResult   = rsp_result_q;
    assign bus.RspOverflow = rsp_ovf_q;
    assign bus.StickyOvf   = sticky_q;
    assign bus.OpCount     = op_count_q;

endmodule

// File: tb/tb_alu_op_controller.sv
// Bench for alu_op_controller: transaction-timestamp reference model, a
// settling ALU model, per-cycle output comparison and directed scenarios.
module tb_alu_op_controller;
    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    alu_op_controller_if #(.WIDTH(W)) bus ();

    alu_op_controller #(.WIDTH(W), .LAT(LAT)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ALU behaviour: {overflow-mux output, result}; non-arith ops leave the mux at 1
    function automatic logic [W:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         o;
        o = 1'b1;
        case (op)
            3'd0: begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            3'd1: begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = a << 1;
            default: r = a >> 1;
        endcase
        return {o, r};
    endfunction

    // Reference model: one op in flight, tracked by the edge it was accepted on
    bit           m_busy = 0, m_ready = 0, m_rsp_valid = 0, m_rsp_ovf = 0, m_sticky = 0;
    logic [2:0]   m_sel = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_rsp_res = '0;
    logic [7:0]   m_count = '0;
    int unsigned  cyc = 0, m_acc_cyc = 0;

    initial begin : model
        bit         hs, cap, acc, busy_n, qual;
        logic [W:0] r;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy <= 0; m_ready <= 0; m_rsp_valid <= 0; m_rsp_ovf <= 0;
                m_sticky <= 0; m_sel <= '0; m_a <= '0; m_b <= '0; m_rsp_res <= '0;
                m_count <= '0; cyc <= 0; m_acc_cyc <= 0;
            end else begin
                hs     = m_rsp_valid && bus.RspReady;
                cap    = m_busy && !m_rsp_valid && (cyc - m_acc_cyc == LAT);
                acc    = m_ready && bus.ReqValid;
                busy_n = acc ? 1'b1 : (hs ? 1'b0 : m_busy);
                r      = alu_ref(m_sel, m_a, m_b);
                qual   = (m_sel < 3'd2) ? r[W] : 1'b0;
                if (acc) begin
                    m_sel <= bus.ReqOp; m_a <= bus.ReqA; m_b <= bus.ReqB; m_acc_cyc <= cyc;
                end
                if (cap) begin
                    m_rsp_valid <= 1; m_rsp_res <= r[W-1:0]; m_rsp_ovf <= qual;
                end else if (hs) begin
                    m_rsp_valid <= 0;
                end
                if (hs) m_count <= m_count + 8'd1;
                if (cap && qual)        m_sticky <= 1;
                else if (bus.ClrSticky) m_sticky <= 0;
                m_busy  <= busy_n;
                m_ready <= !busy_n;
                cyc     <= cyc + 1;
            end
        end
    end

    // ALU drives garbage until LAT cycles after launch so early capture is visible
    logic       settled;
    logic [W:0] alu_true;
    assign settled  = (cyc - m_acc_cyc) >= LAT;
    assign alu_true = alu_ref(bus.AluSel, bus.AluA, bus.AluB);
    assign bus.AluResult   = settled ? alu_true[W-1:0] : (alu_true[W-1:0] ^ 8'hA5);
    assign bus.AluOverflow = settled ? alu_true[W] : ~alu_true[W];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ReqReady",    32'(bus.ReqReady),    32'(m_ready));
            chk("AluSel",      32'(bus.AluSel),      32'(m_sel));
            chk("AluA",        32'(bus.AluA),        32'(m_a));
            chk("AluB",        32'(bus.AluB),        32'(m_b));
            chk("RspValid",    32'(bus.RspValid),    32'(m_rsp_valid));
            chk("RspResult",   32'(bus.RspResult),   32'(m_rsp_res));
            chk("RspOverflow", 32'(bus.RspOverflow), 32'(m_rsp_ovf));
            chk("StickyOvf",   32'(bus.StickyOvf),   32'(m_sticky));
            chk("OpCount",     32'(bus.OpCount),     32'(m_count));
        end
    end

    // Offer a request at a negedge; return at the negedge after the accept edge
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.ReqValid = 1'b1; bus.ReqOp = op; bus.ReqA = a; bus.ReqB = b;
        while (!bus.ReqReady && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("send_timeout", 32'(bus.ReqReady), 32'd1);
        @(negedge clk);
        bus.ReqValid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!bus.RspValid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rsp_timeout", 32'(bus.RspValid), 32'd1);
    endtask

    task automatic handshake();
        bus.RspReady = 1'b1;
        @(negedge clk);
        bus.RspReady = 1'b0;
    endtask

    task automatic clear_sticky();
        bus.ClrSticky = 1'b1;
        @(negedge clk);
        bus.ClrSticky = 1'b0;
    endtask

    initial begin : stim
        int n_acc, guard, last;
        bit saw255;
        bus.ReqValid = 0; bus.ReqOp = '0; bus.ReqA = '0; bus.ReqB = '0;
        bus.RspReady = 0; bus.ClrSticky = 0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_ReqReady", 32'(bus.ReqReady), 32'd0);
        chk("rst_RspValid", 32'(bus.RspValid), 32'd0);
        chk("rst_AluA",     32'(bus.AluA),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(bus.ReqReady), 32'd1);

        // Add with overflow
        send(3'd0, 8'h7F, 8'h01);
        chk("add_AluSel", 32'(bus.AluSel), 32'd0);
        chk("add_no_early_valid", 32'(bus.RspValid), 32'd0);
        @(negedge clk);
        chk("add_no_valid_edge1", 32'(bus.RspValid), 32'd0);
        @(negedge clk);
        chk("add_valid_edge2", 32'(bus.RspValid),    32'd1);
        chk("add_result",      32'(bus.RspResult),   32'h80);
        chk("add_ovf",         32'(bus.RspOverflow), 32'd1);
        chk("add_sticky",      32'(bus.StickyOvf),   32'd1);
        handshake();
        chk("add_opcount", 32'(bus.OpCount), 32'd1);

        // Non-arithmetic op with overflow mux driving 1
        clear_sticky();
        chk("sticky_cleared", 32'(bus.StickyOvf), 32'd0);
        send(3'd3, 8'hF0, 8'h0F);
        wait_rsp();
        chk("or_result", 32'(bus.RspResult),   32'hFF);
        chk("or_ovf",    32'(bus.RspOverflow), 32'd0);
        chk("or_sticky", 32'(bus.StickyOvf),   32'd0);
        handshake();

        // Response backpressure with a second request pending
        send(3'd1, 8'h05, 8'h07);
        wait_rsp();
        chk("sub_result", 32'(bus.RspResult),   32'hFE);
        chk("sub_ovf",    32'(bus.RspOverflow), 32'd0);
        bus.ReqValid = 1'b1; bus.ReqOp = 3'd2; bus.ReqA = 8'h33; bus.ReqB = 8'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid",  32'(bus.RspValid),  32'd1);
            chk("stall_result", 32'(bus.RspResult), 32'hFE);
            chk("stall_ready",  32'(bus.ReqReady),  32'd0);
        end
        handshake();
        chk("post_hs_ready",     32'(bus.ReqReady), 32'd1);
        chk("post_hs_not_taken", 32'(bus.AluA),     32'h05);
        @(negedge clk);
        bus.ReqValid = 1'b0;
        chk("second_taken_A", 32'(bus.AluA),   32'h33);
        chk("second_taken_S", 32'(bus.AluSel), 32'd2);
        wait_rsp();
        handshake();

        // Sticky set/clear collision: -128 + -1 overflows
        send(3'd0, 8'h80, 8'hFF);
        @(negedge clk);
        bus.ClrSticky = 1'b1;
        @(negedge clk);
        chk("collide_valid",  32'(bus.RspValid),  32'd1);
        chk("collide_sticky", 32'(bus.StickyOvf), 32'd1);
        @(negedge clk);
        bus.ClrSticky = 1'b0;
        chk("clear_alone", 32'(bus.StickyOvf), 32'd0);
        handshake();

        // Reset one cycle after acceptance
        send(3'd0, 8'h7F, 8'h01);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready",   32'(bus.ReqReady),  32'd0);
        chk("midrst_valid",   32'(bus.RspValid),  32'd0);
        chk("midrst_sel",     32'(bus.AluSel),    32'd0);
        chk("midrst_A",       32'(bus.AluA),      32'd0);
        chk("midrst_count",   32'(bus.OpCount),   32'd0);
        chk("midrst_sticky",  32'(bus.StickyOvf), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", 32'(bus.ReqReady), 32'd1);
        chk("midrst_no_valid",    32'(bus.RspValid), 32'd0);

        // 256 back-to-back ops: issue interval and counter wrap
        bus.RspReady = 1'b1; bus.ReqValid = 1'b1;
        n_acc = 0; guard = 0; last = 0; saw255 = 0;
        while (n_acc < 256 && guard < 256 * (LAT + 2) + 20) begin
            bus.ReqOp = 3'($urandom_range(7));
            bus.ReqA  = 8'($urandom); bus.ReqB = 8'($urandom);
            if (bus.ReqReady) begin
                if (n_acc > 0) chk("issue_interval", 32'(guard - last), 32'(LAT + 2));
                last = guard;
                n_acc++;
            end
            if (bus.OpCount == 8'd255) saw255 = 1'b1;
            @(negedge clk);
            guard++;
        end
        bus.ReqValid = 1'b0;
        if (n_acc < 256) chk("wrap_accepts", 32'(n_acc), 32'd256);
        repeat (LAT + 1) @(negedge clk);
        bus.RspReady = 1'b0;
        chk("wrap_saw255", 32'(saw255),      32'd1);
        chk("wrap_zero",   32'(bus.OpCount), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.ReqValid  = ($urandom_range(1) == 1);
            bus.ReqOp     = 3'($urandom_range(7));
            bus.ReqA      = 8'($urandom);
            bus.ReqB      = 8'($urandom);
            bus.RspReady  = ($urandom_range(4) > 1);
            bus.ClrSticky = ($urandom_range(15) == 0);
            @(negedge clk);
        end
        bus.ReqValid = 0; bus.RspReady = 0; bus.ClrSticky = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
